// File: rtl/sprite_pkg.sv
// Shared types and constants for the rotating sprite bank.
// Sprite facing and the pixel encodings the RGB mux treats specially.
package sprite_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_t;

  localparam logic [7:0] TRANSPARENT_ENCODING = 8'hFF;
  localparam logic [7:0] RESET_RGB            = 8'h00;

endpackage

// File: rtl/sprite_anim_counter.sv
// Per-sprite animation state: a tick prescaler over video frames feeding a
// wrapping frame counter. Disabling the sprite clears both immediately.
module sprite_anim_counter #(
  parameter int ANIM_FRAMES = 4,
  parameter int ANIM_PERIOD = 8,
  localparam int FRAME_W = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1,
  localparam int TICK_W  = (ANIM_PERIOD > 1) ? $clog2(ANIM_PERIOD) : 1
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               enable,
  input  logic               moving,
  output logic [FRAME_W-1:0] frame
);

  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [FRAME_W-1:0] frame_q, frame_d;

  always_comb begin
    tick_d  = tick_q;
    frame_d = frame_q;
    if (!enable) begin
      tick_d  = '0;
      frame_d = '0;
    end else if (startOfFrame && moving) begin
      if (tick_q == TICK_W'(ANIM_PERIOD - 1)) begin
        tick_d  = '0;
        frame_d = (frame_q == FRAME_W'(ANIM_FRAMES - 1)) ? '0 : frame_q + 1'b1;
      end else begin
        tick_d = tick_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      tick_q  <= '0;
      frame_q <= '0;
    end else begin
      tick_q  <= tick_d;
      frame_q <= frame_d;
    end
  end

  assign frame = frame_q;

endmodule

// File: rtl/rotating_sprite_bank.sv
// Hit-tests the current VGA pixel against NUM_OBJ frame-latched square sprites
// and emits the lowest-index winner's rotated bitmap offset two clocks later.
module rotating_sprite_bank
  import sprite_pkg::*;
#(
  parameter int          NUM_OBJ      = 4,
  parameter int          OBJECT_SIZE  = 32,
  parameter int          COORD_W      = 11,
  parameter int          ANIM_FRAMES  = 4,
  parameter int          ANIM_PERIOD  = 8,
  parameter logic [7:0]  OBJECT_COLOR = 8'h5b,
  localparam int OFF_W   = $clog2(OBJECT_SIZE),
  localparam int IDX_W   = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1,
  localparam int FRAME_W = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1
) (
  input  logic                            clk,
  input  logic                            resetN,
  input  logic                            startOfFrame,
  input  logic [COORD_W-1:0]              pixelX,
  input  logic [COORD_W-1:0]              pixelY,
  input  logic [NUM_OBJ-1:0][COORD_W-1:0] topLeftX,
  input  logic [NUM_OBJ-1:0][COORD_W-1:0] topLeftY,
  input  logic [NUM_OBJ-1:0][1:0]         objDir,
  input  logic [NUM_OBJ-1:0]              objEnable,
  input  logic [NUM_OBJ-1:0]              objMoving,
  output logic [OFF_W-1:0]                offsetX,
  output logic [OFF_W-1:0]                offsetY,
  output logic [IDX_W-1:0]                objIndex,
  output logic [FRAME_W-1:0]              animFrame,
  output logic                            drawingRequest,
  output logic [7:0]                      RGBout
);

  localparam logic [OFF_W-1:0] SIDE_MAX = OFF_W'(OBJECT_SIZE - 1);

  logic [NUM_OBJ-1:0][COORD_W-1:0] shX_q, shY_q;
  logic [NUM_OBJ-1:0][1:0]         shDir_q;
  logic [NUM_OBJ-1:0]              shEn_q;
  logic [NUM_OBJ-1:0][FRAME_W-1:0] frameCnt;

  // Positions are frozen at frame start so a sprite never tears mid-frame.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      shX_q   <= '0;
      shY_q   <= '0;
      shDir_q <= '0;
      shEn_q  <= '0;
    end else if (startOfFrame) begin
      shX_q   <= topLeftX;
      shY_q   <= topLeftY;
      shDir_q <= objDir;
      shEn_q  <= objEnable;
    end
  end

  for (genvar g = 0; g < NUM_OBJ; g++) begin : g_anim
    sprite_anim_counter #(
      .ANIM_FRAMES (ANIM_FRAMES),
      .ANIM_PERIOD (ANIM_PERIOD)
    ) u_anim (
      .clk          (clk),
      .resetN       (resetN),
      .startOfFrame (startOfFrame),
      .enable       (objEnable[g]),
      .moving       (objMoving[g]),
      .frame        (frameCnt[g])
    );
  end

  logic [NUM_OBJ-1:0][COORD_W:0]   relX, relY;
  logic [NUM_OBJ-1:0]              s1Hit_d, s1Hit_q;
  logic [NUM_OBJ-1:0][OFF_W-1:0]   s1Rx_d, s1Rx_q, s1Ry_d, s1Ry_q;
  logic [NUM_OBJ-1:0][1:0]         s1Dir_q;
  logic [NUM_OBJ-1:0][FRAME_W-1:0] s1Frame_q;
  logic                            s1Valid_q;

  // The extra sign bit keeps pixels left of / above a sprite from wrapping in.
  always_comb begin
    relX    = '0;
    relY    = '0;
    s1Hit_d = '0;
    s1Rx_d  = '0;
    s1Ry_d  = '0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      relX[i]    = {1'b0, pixelX} - {1'b0, shX_q[i]};
      relY[i]    = {1'b0, pixelY} - {1'b0, shY_q[i]};
      s1Hit_d[i] = shEn_q[i] && (relX[i][COORD_W:OFF_W] == '0)
                             && (relY[i][COORD_W:OFF_W] == '0);
      s1Rx_d[i]  = relX[i][OFF_W-1:0];
      s1Ry_d[i]  = relY[i][OFF_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      s1Hit_q   <= '0;
      s1Rx_q    <= '0;
      s1Ry_q    <= '0;
      s1Dir_q   <= '0;
      s1Frame_q <= '0;
      s1Valid_q <= 1'b0;
    end else begin
      s1Hit_q   <= s1Hit_d;
      s1Rx_q    <= s1Rx_d;
      s1Ry_q    <= s1Ry_d;
      s1Dir_q   <= shDir_q;
      s1Frame_q <= frameCnt;
      s1Valid_q <= 1'b1;
    end
  end

  logic                selFound;
  logic [IDX_W-1:0]    selIdx;
  logic [OFF_W-1:0]    selRx, selRy;
  logic [1:0]          selDir;
  logic [FRAME_W-1:0]  selFrame;

  always_comb begin
    selFound = 1'b0;
    selIdx   = '0;
    selRx    = '0;
    selRy    = '0;
    selDir   = '0;
    selFrame = '0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (!selFound && s1Hit_q[i]) begin
        selFound = 1'b1;
        selIdx   = IDX_W'(i);
        selRx    = s1Rx_q[i];
        selRy    = s1Ry_q[i];
        selDir   = s1Dir_q[i];
        selFrame = s1Frame_q[i];
      end
    end
  end

  logic                offX_d, offX_q_unused;
  logic [OFF_W-1:0]    offsetX_d, offsetX_q, offsetY_d, offsetY_q;
  logic [IDX_W-1:0]    objIndex_d, objIndex_q;
  logic [FRAME_W-1:0]  animFrame_d, animFrame_q;
  logic                drawReq_d, drawReq_q;
  logic [7:0]          rgb_d, rgb_q;

  assign offX_d        = 1'b0;
  assign offX_q_unused = offX_d;

  // Until the pipeline refills after reset, outputs keep their reset values.
  always_comb begin
    drawReq_d   = 1'b0;
    rgb_d       = RESET_RGB;
    offsetX_d   = '0;
    offsetY_d   = '0;
    objIndex_d  = '0;
    animFrame_d = '0;
    if (s1Valid_q) begin
      rgb_d = TRANSPARENT_ENCODING;
      if (selFound) begin
        drawReq_d   = 1'b1;
        rgb_d       = OBJECT_COLOR;
        objIndex_d  = selIdx;
        animFrame_d = selFrame;
        case (dir_t'(selDir))
          DIR_UP: begin
            offsetX_d = SIDE_MAX - selRy;
            offsetY_d = selRx;
          end
          DIR_RIGHT: begin
            offsetX_d = selRx;
            offsetY_d = selRy;
          end
          DIR_DOWN: begin
            offsetX_d = selRy;
            offsetY_d = SIDE_MAX - selRx;
          end
          DIR_LEFT: begin
            offsetX_d = SIDE_MAX - selRx;
            offsetY_d = SIDE_MAX - selRy;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      drawReq_q   <= 1'b0;
      rgb_q       <= RESET_RGB;
      offsetX_q   <= '0;
      offsetY_q   <= '0;
      objIndex_q  <= '0;
      animFrame_q <= '0;
    end else begin
      drawReq_q   <= drawReq_d;
      rgb_q       <= rgb_d;
      offsetX_q   <= offsetX_d;
      offsetY_q   <= offsetY_d;
      objIndex_q  <= objIndex_d;
      animFrame_q <= animFrame_d;
    end
  end

  assign drawingRequest = drawReq_q;
  assign RGBout         = rgb_q;
  assign offsetX        = offsetX_q;
  assign offsetY        = offsetY_q;
  assign objIndex       = objIndex_q;
  assign animFrame      = animFrame_q;

endmodule

// File: tb/tb_rotating_sprite_bank.sv
// Directed plus randomized bench for rotating_sprite_bank, checked against a
// pixel-level reference model of frame latching, hit priority and rotation.
module tb_rotating_sprite_bank;

  localparam int NUM_OBJ = 4;
  localparam int S       = 32;
  localparam int PERIOD  = 8;
  localparam int FRAMES  = 4;

  logic                  clk = 1'b0;
  logic                  resetN;
  logic                  startOfFrame;
  logic [10:0]           pixelX, pixelY;
  logic [3:0][10:0]      topLeftX, topLeftY;
  logic [3:0][1:0]       objDir;
  logic [3:0]            objEnable, objMoving;
  logic [4:0]            offsetX, offsetY;
  logic [1:0]            objIndex, animFrame;
  logic                  drawingRequest;
  logic [7:0]            RGBout;

  rotating_sprite_bank #(
    .NUM_OBJ      (NUM_OBJ),
    .OBJECT_SIZE  (S),
    .COORD_W      (11),
    .ANIM_FRAMES  (FRAMES),
    .ANIM_PERIOD  (PERIOD),
    .OBJECT_COLOR (8'h5b)
  ) dut (
    .clk            (clk),
    .resetN         (resetN),
    .startOfFrame   (startOfFrame),
    .pixelX         (pixelX),
    .pixelY         (pixelY),
    .topLeftX       (topLeftX),
    .topLeftY       (topLeftY),
    .objDir         (objDir),
    .objEnable      (objEnable),
    .objMoving      (objMoving),
    .offsetX        (offsetX),
    .offsetY        (offsetY),
    .objIndex       (objIndex),
    .animFrame      (animFrame),
    .drawingRequest (drawingRequest),
    .RGBout         (RGBout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       draw;
    logic [7:0] rgb;
    logic [4:0] ox;
    logic [4:0] oy;
    logic [1:0] idx;
    logic [1:0] frame;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   mShX[NUM_OBJ], mShY[NUM_OBJ], mShDir[NUM_OBJ];
  bit   mShEn[NUM_OBJ];
  int   mTick[NUM_OBJ], mFrame[NUM_OBJ];
  exp_t pending[$];

  function automatic exp_t mk(logic d, logic [7:0] rgb, int ox, int oy, int idx, int fr);
    exp_t e;
    e.draw  = d;
    e.rgb   = rgb;
    e.ox    = 5'(ox);
    e.oy    = 5'(oy);
    e.idx   = 2'(idx);
    e.frame = 2'(fr);
    return e;
  endfunction

  // What the screen should show for the pixel currently on the inputs.
  function automatic exp_t modelOut();
    exp_t e;
    int   rx, ry;
    bit   found;
    e       = '0;
    e.rgb   = 8'hFF;
    found   = 1'b0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      rx = int'(pixelX) - mShX[i];
      ry = int'(pixelY) - mShY[i];
      if (!found && mShEn[i] && rx >= 0 && rx < S && ry >= 0 && ry < S) begin
        found = 1'b1;
        case (mShDir[i])
          0:       e = mk(1'b1, 8'h5b, S - 1 - ry, rx, i, mFrame[i]);
          1:       e = mk(1'b1, 8'h5b, rx, ry, i, mFrame[i]);
          2:       e = mk(1'b1, 8'h5b, ry, S - 1 - rx, i, mFrame[i]);
          default: e = mk(1'b1, 8'h5b, S - 1 - rx, S - 1 - ry, i, mFrame[i]);
        endcase
      end
    end
    return e;
  endfunction

  task automatic modelAdvance();
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (startOfFrame) begin
        mShX[i]   = int'(topLeftX[i]);
        mShY[i]   = int'(topLeftY[i]);
        mShDir[i] = int'(objDir[i]);
        mShEn[i]  = objEnable[i];
      end
      if (!objEnable[i]) begin
        mTick[i]  = 0;
        mFrame[i] = 0;
      end else if (startOfFrame && objMoving[i]) begin
        mTick[i] = mTick[i] + 1;
        if (mTick[i] == PERIOD) begin
          mTick[i]  = 0;
          mFrame[i] = (mFrame[i] + 1) % FRAMES;
        end
      end
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NUM_OBJ; i++) begin
      mShX[i] = 0; mShY[i] = 0; mShDir[i] = 0; mShEn[i] = 1'b0;
      mTick[i] = 0; mFrame[i] = 0;
    end
    pending.delete();
  endtask

  task automatic checkOutput(input string tag, input exp_t e);
    checks++;
    assert (drawingRequest === e.draw) else begin
      errors++;
      $error("FAIL %s drawingRequest observed %0b expected %0b", tag, drawingRequest, e.draw);
    end
    checks++;
    assert (RGBout === e.rgb) else begin
      errors++;
      $error("FAIL %s RGBout observed %02h expected %02h", tag, RGBout, e.rgb);
    end
    checks++;
    assert (offsetX === e.ox) else begin
      errors++;
      $error("FAIL %s offsetX observed %0d expected %0d", tag, offsetX, e.ox);
    end
    checks++;
    assert (offsetY === e.oy) else begin
      errors++;
      $error("FAIL %s offsetY observed %0d expected %0d", tag, offsetY, e.oy);
    end
    checks++;
    assert (objIndex === e.idx) else begin
      errors++;
      $error("FAIL %s objIndex observed %0d expected %0d", tag, objIndex, e.idx);
    end
    checks++;
    assert (animFrame === e.frame) else begin
      errors++;
      $error("FAIL %s animFrame observed %0d expected %0d", tag, animFrame, e.frame);
    end
  endtask

  // One pixel clock: predict, clock, then compare the pixel from two clocks back.
  task automatic applyStimulus();
    pending.push_back(modelOut());
    modelAdvance();
    @(posedge clk);
    #1;
    startOfFrame = 1'b0;
    if (pending.size() >= 2) checkOutput("pipe", pending.pop_front());
  endtask

  task automatic sof();
    startOfFrame = 1'b1;
    applyStimulus();
  endtask

  task automatic hold(input int n);
    repeat (n) applyStimulus();
  endtask

  task automatic setPix(input int x, input int y);
    pixelX = 11'(x);
    pixelY = 11'(y);
  endtask

  task automatic runFrames(input int n);
    repeat (n) begin
      sof();
      hold(2);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired before summary");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int rotDir[3];
    int rotX[3];
    int rotY[3];
    rotDir = '{0, 2, 3};
    rotX   = '{21, 10, 26};
    rotY   = '{5, 26, 21};

    resetN       = 1'b0;
    startOfFrame = 1'b0;
    setPix(0, 0);
    for (int i = 0; i < NUM_OBJ; i++) begin
      topLeftX[i] = 11'(1200 + i * 100);
      topLeftY[i] = 11'(1200 + i * 100);
    end
    objDir    = '0;
    objEnable = '0;
    objMoving = '0;
    modelReset();
    #12;
    checkOutput("reset", mk(1'b0, 8'h00, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    resetN = 1'b1;

    $display("[TB] single sprite facing right");
    topLeftX[0] = 11'd100; topLeftY[0] = 11'd50; objDir[0] = 2'b01; objEnable[0] = 1'b1;
    sof();
    setPix(105, 60); hold(2);
    checkOutput("right_hit", mk(1'b1, 8'h5b, 5, 10, 0, 0));
    setPix(132, 60); hold(2);
    checkOutput("right_miss", mk(1'b0, 8'hFF, 0, 0, 0, 0));

    $display("[TB] rotations");
    for (int k = 0; k < 3; k++) begin
      objDir[0] = 2'(rotDir[k]);
      sof();
      setPix(105, 60); hold(2);
      checkOutput("rotate", mk(1'b1, 8'h5b, rotX[k], rotY[k], 0, 0));
    end
    objDir[0] = 2'b01;
    sof();

    $display("[TB] overlap priority");
    topLeftX[1] = 11'd190; topLeftY[1] = 11'd190; objDir[1] = 2'b01; objEnable[1] = 1'b1;
    topLeftX[2] = 11'd195; topLeftY[2] = 11'd195; objDir[2] = 2'b01; objEnable[2] = 1'b1;
    sof();
    setPix(200, 200); hold(2);
    checkOutput("prio_1", mk(1'b1, 8'h5b, 10, 10, 1, 0));
    objEnable[1] = 1'b0;
    sof();
    hold(2);
    checkOutput("prio_2", mk(1'b1, 8'h5b, 5, 5, 2, 0));

    $display("[TB] frame latching");
    topLeftX[0] = 11'd300;
    setPix(105, 60); hold(2);
    checkOutput("latch_old", mk(1'b1, 8'h5b, 5, 10, 0, 0));
    setPix(305, 60); hold(2);
    checkOutput("latch_new_early", mk(1'b0, 8'hFF, 0, 0, 0, 0));
    setPix(105, 60);
    sof();
    setPix(306, 61);
    applyStimulus();
    checkOutput("latch_sof_pixel", mk(1'b1, 8'h5b, 5, 10, 0, 0));
    applyStimulus();
    checkOutput("latch_moved", mk(1'b1, 8'h5b, 6, 11, 0, 0));
    setPix(105, 60); hold(2);
    checkOutput("latch_old_gone", mk(1'b0, 8'hFF, 0, 0, 0, 0));

    $display("[TB] animation");
    objMoving[0] = 1'b1;
    setPix(305, 60);
    runFrames(8);
    checkOutput("anim_step", mk(1'b1, 8'h5b, 5, 10, 0, 1));
    runFrames(24);
    checkOutput("anim_wrap", mk(1'b1, 8'h5b, 5, 10, 0, 0));
    runFrames(8);
    objMoving[0] = 1'b0;
    runFrames(10);
    checkOutput("anim_hold", mk(1'b1, 8'h5b, 5, 10, 0, 1));
    objEnable[0] = 1'b0;
    applyStimulus();
    objEnable[0] = 1'b1;
    sof();
    hold(2);
    checkOutput("anim_clear", mk(1'b1, 8'h5b, 5, 10, 0, 0));

    $display("[TB] right screen edge");
    topLeftX[3] = 11'd2040; topLeftY[3] = 11'd10; objDir[3] = 2'b01; objEnable[3] = 1'b1;
    sof();
    setPix(2047, 15); hold(2);
    checkOutput("edge_hit", mk(1'b1, 8'h5b, 7, 5, 3, 0));
    setPix(0, 15); hold(2);
    checkOutput("edge_nowrap", mk(1'b0, 8'hFF, 0, 0, 0, 0));

    $display("[TB] randomized traffic");
    objEnable = 4'hF;
    objMoving = 4'hF;
    for (int n = 0; n < 400; n++) begin
      int j;
      int base;
      j = int'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        base = ($urandom_range(0, 3) == 0) ? 2000 : 100;
        topLeftX[j] = 11'(base + int'($urandom_range(0, 47)));
        topLeftY[j] = 11'(50 + int'($urandom_range(0, 47)));
      end
      if ($urandom_range(0, 7) == 0) objDir[j] = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) objEnable = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) objMoving = 4'($urandom_range(0, 15));
      startOfFrame = ($urandom_range(0, 7) == 0);
      j = int'($urandom_range(0, 3));
      pixelX = 11'(int'(topLeftX[j]) + int'($urandom_range(0, 40)) - 4);
      pixelY = 11'(int'(topLeftY[j]) + int'($urandom_range(0, 40)) - 4);
      applyStimulus();
    end

    $display("[TB] reset mid-line");
    objEnable = 4'b0001;
    objMoving = '0;
    topLeftX[0] = 11'd100; topLeftY[0] = 11'd50; objDir[0] = 2'b01;
    sof();
    setPix(105, 60); hold(3);
    checkOutput("pre_reset_hit", mk(1'b1, 8'h5b, 5, 10, 0, 0));
    resetN = 1'b0;
    #2;
    checkOutput("reset_midline", mk(1'b0, 8'h00, 0, 0, 0, 0));
    modelReset();
    @(posedge clk);
    @(posedge clk);
    #1;
    resetN = 1'b1;
    hold(4);
    checkOutput("post_reset_nohit", mk(1'b0, 8'hFF, 0, 0, 0, 0));
    sof();
    hold(2);
    checkOutput("post_reset_hit", mk(1'b1, 8'h5b, 5, 10, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rotating_sprite_bank.md
# rotating_sprite_bank

Multi-instance successor to the single tank square object. It tracks NUM_OBJ square sprites (player and enemy tanks), latches their positions once per frame to prevent tearing, and hit-tests the current VGA pixel against all of them. Among the hits, the lowest index wins. The block outputs direction-rotated bitmap offsets, the winning object index and a per-object animation frame. It sits between the game-logic position registers and the bitmap ROMs and RGB mux, in the VGA pipeline.

## Interface
Parameters:
- NUM_OBJ, 4, number of sprite instances (1..8)
- OBJECT_SIZE, 32, square side in pixels; power of two
- COORD_W, 11, pixel/position coordinate width
- ANIM_FRAMES, 4, animation frames per sprite; power of two
- ANIM_PERIOD, 8, video frames per animation step (≥1)
- OBJECT_COLOR, 8'h5b, RGB output for a hit pixel

Ports:
- clk  in  1  pixel clock
- resetN  in  1  asynchronous, active-low reset
- startOfFrame  in  1  one-cycle pulse at the start of each frame
- pixelX, pixelY  in  COORD_W each  current VGA pixel
- topLeftX, topLeftY  in  [NUM_OBJ][COORD_W]  live sprite positions
- objDir  in  [NUM_OBJ][2]  direction: 00 up, 01 right, 10 down, 11 left
- objEnable  in  NUM_OBJ  sprite is visible
- objMoving  in  NUM_OBJ  animation advances
- offsetX, offsetY  out  $clog2(OBJECT_SIZE) each  rotated bitmap offset
- objIndex  out  $clog2(NUM_OBJ) (min 1)  winning sprite
- animFrame  out  $clog2(ANIM_FRAMES)  winner's animation frame
- drawingRequest  out  1  pixel is inside a winning sprite
- RGBout  out  8  OBJECT_COLOR on a hit, otherwise 8'hFF

## Operation
- **Shadow registers.** On startOfFrame, copy topLeftX/Y, objDir and objEnable into shadow registers. Hit-testing uses only the shadow copies. The live inputs are ignored mid-frame.
- **Hit test (stage 1).** For each i:
  - rx = pixelX − shX[i] and ry = pixelY − shY[i], computed as COORD_W+1-bit signed values.
  - hit[i] = shEn[i] && 0 ≤ rx < OBJECT_SIZE && 0 ≤ ry < OBJECT_SIZE.
  - No wrap: a sprite at topLeftX = 2040 covers only pixelX 2040..2047.
- **Select and rotate (stage 2).** Find the lowest i with hit[i]. With S = OBJECT_SIZE:
  - up: offsetX = S−1−ry, offsetY = rx
  - right: offsetX = rx, offsetY = ry
  - down: offsetX = ry, offsetY = S−1−rx
  - left: offsetX = S−1−rx, offsetY = S−1−ry
- **No hit.** drawingRequest=0, RGBout=8'hFF; offsetX, offsetY, objIndex and animFrame all 0.
- **Animation, per object.**
  - Each object has a tick counter 0..ANIM_PERIOD−1 and a frame counter 0..ANIM_FRAMES−1.
  - On startOfFrame with objMoving[i]=1: the tick counter increments. When it wraps at ANIM_PERIOD−1, the frame counter increments mod ANIM_FRAMES.
  - objMoving[i]=0: both counters hold.
  - objEnable[i]=0, sampled live: both counters clear to 0.
- **Simultaneous events.** When startOfFrame and a pixel arrive in the same cycle, that pixel is tested against the old shadow values.

## Timing
- **Latency.** 2 clocks from pixelX/Y to all outputs, fully pipelined at one pixel per clock. All outputs change together.
- **Shadow update.** Shadow values take effect for pixels presented on the cycle after the startOfFrame pulse.
- **Animation update.** animFrame updates in the cycle after the startOfFrame pulse.
- **Reset.** Asynchronous. Clears:
  - all shadow registers, including enable=0;
  - all counters;
  - both pipeline stages.
  
  Output values during reset: drawingRequest=0, RGBout=8'h00, offsets/objIndex/animFrame=0. The first valid output appears 2 clocks after release. A reset mid-frame discards in-flight pixels.

## Structure
- **Package sprite_pkg:**
  - dir_t enum: DIR_UP=2'b00, DIR_RIGHT=2'b01, DIR_DOWN=2'b10, DIR_LEFT=2'b11
  - TRANSPARENT_ENCODING = 8'hFF
- **Sub-module sprite_anim_counter (parameters ANIM_FRAMES, ANIM_PERIOD).**
  - Ports: clk, resetN, startOfFrame, enable, moving, frame.
  - Instantiated NUM_OBJ times through a generate loop.

## Test plan
- **Single sprite, right.** Sprite 0 at (100,50), enabled, dir 01, startOfFrame. Pixel (105,60) → 2 clocks later drawingRequest=1, RGBout=8'h5b, offset (5,10), objIndex=0. Pixel (132,60) → drawingRequest=0, RGBout=8'hFF.
- **Rotation.** Same sprite and pixel with dir 00 / 10 / 11 → offsets (21,5) / (10,26) / (26,21).
- **Overlap priority.** Sprites 1 and 2 both cover (200,200) → objIndex=1. Disable sprite 1, then startOfFrame → objIndex=2.
- **Frame latching.** Move topLeftX of sprite 0 from 100 to 300 mid-frame → hits stay at 100 until the next startOfFrame, then move to 300. A pixel in the same cycle as the startOfFrame pulse still uses 100.
- **Animation.** ANIM_PERIOD=8, objMoving=1: 8 startOfFrame pulses → animFrame 0→1; 32 pulses → wraps to 0. Set objMoving=0 → animFrame holds. Drop enable → animFrame clears to 0.
- **Edge and reset.** Sprite at X=2040 → pixelX 2047 hits and pixelX 0 misses. Assert resetN low mid-line → all outputs 0 immediately; after release, outputs stay no-hit until a startOfFrame and a re-enable.
